full_adder: RTL and testbench

//  Registered ripple-carry adder built from 1-bit full-adder cells: {c,s} = x + y + z.

---
 rtl/full_adder_pkg.sv | 13 +
 rtl/full_adder_bit.sv | 14 +
 rtl/full_adder.sv | 56 +++++
 tb/tb_full_adder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared bit-cell arithmetic for the ripple-carry full adder.
package full_adder_pkg;

    // Returns {cout, sum} for a single full-adder cell.
    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        logic sum;
        logic cout;
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
        return {cout, sum};
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One combinational full-adder cell: a link of the ripple chain.
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign {cout, sum} = fa_cell(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder {c,s} = x + y + z with optional registered output stage.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             out_valid
);

    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    assign carry_p0[0] = z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a   (x[i]),
            .b   (y[i]),
            .cin (carry_p0[i]),
            .sum (sum_p0[i]),
            .cout(carry_p0[i+1])
        );
    end

    // ---- stage p0 -> p1: result register (or bypass) ----
    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s         <= '0;
                c         <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    s <= sum_p0;
                    c <= carry_p0[WIDTH];
                end
            end
        end
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign s         = sum_p0;
        assign c         = carry_p0[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// Randomized and directed checks of full_adder against an arithmetic reference.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic       x1, y1, z1, v1;
    logic       s1, c1, ov1;
    logic       sc, cc, ovc;
    logic [3:0] x4, y4, s4;
    logic       z4, v4, c4, ov4;

    int total = 0;
    int bad   = 0;

    // Reference state: last accepted sum per registered instance.
    logic [1:0] exp1;
    logic [4:0] exp4;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .in_valid(v1),
        .s(s1), .c(c1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .in_valid(v1),
        .s(sc), .c(cc), .out_valid(ovc)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .z(z4), .in_valid(v4),
        .s(s4), .c(c4), .out_valid(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b1; v1 = 1'b1;
        x4 = 4'h0; y4 = 4'h0; z4 = 1'b0; v4 = 1'b0;

        // Reset held across an edge with all-ones inputs.
        #12;
        chk("rst_s", 32'(s1), 32'd0);
        chk("rst_c", 32'(c1), 32'd0);
        chk("rst_ov", 32'(ov1), 32'd0);
        chk("rst_ov4", 32'(ov4), 32'd0);
        chk("rst_s4", 32'(s4), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("rel_s", 32'(s1), 32'd1);
        chk("rel_c", 32'(c1), 32'd1);
        chk("rel_ov", 32'(ov1), 32'd1);

        // All eight (x,y,z) combinations.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            {x1, y1, z1} = v;
            v1 = 1'b1;
            #1;
            chk("comb_cs", 32'({cc, sc}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
            chk("comb_ov", 32'(ovc), 32'd1);
            @(posedge clk) #1;
            chk("w1_cs", 32'({c1, s1}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
            chk("w1_ov", 32'(ov1), 32'd1);
        end

        // Hold: result 1+1+0, then drop in_valid and change inputs.
        @(negedge clk);
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b0; v1 = 1'b1;
        @(posedge clk) #1;
        chk("hold_pre", 32'({c1, s1}), 32'b10);
        @(negedge clk);
        x1 = 1'b0; y1 = 1'b1; z1 = 1'b1; v1 = 1'b0;
        #1;
        chk("comb_ov_lo", 32'(ovc), 32'd0);
        @(posedge clk) #1;
        chk("hold_cs", 32'({c1, s1}), 32'b10);
        chk("hold_ov", 32'(ov1), 32'd0);

        // Mid-cycle reset must clear outputs without waiting for an edge.
        @(negedge clk);
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b1; v1 = 1'b1;
        @(posedge clk) #1;
        chk("mid_pre", 32'({ov1, c1, s1}), 32'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'({ov1, c1, s1}), 32'b000);
        @(negedge clk);
        rst_n = 1'b1;
        x1 = 1'b1; y1 = 1'b0; z1 = 1'b0;
        @(posedge clk) #1;
        chk("mid_after", 32'({ov1, c1, s1}), 32'b101);
        exp4 = 5'd0;

        // WIDTH=4 boundaries.
        @(negedge clk);
        x4 = 4'hF; y4 = 4'h1; z4 = 1'b0; v4 = 1'b1;
        @(posedge clk) #1;
        chk("w4_f1", 32'({c4, s4}), 32'h10);
        @(negedge clk);
        x4 = 4'hF; y4 = 4'hF; z4 = 1'b1;
        @(posedge clk) #1;
        chk("w4_ff1", 32'({c4, s4}), 32'h1F);
        @(negedge clk);
        x4 = 4'h0; y4 = 4'h0; z4 = 1'b0;
        @(posedge clk) #1;
        chk("w4_zero", 32'({c4, s4}), 32'h00);
        chk("w4_ov", 32'(ov4), 32'd1);
        exp4 = 5'd0;
        exp1 = {c1, s1} === 2'b01 ? 2'b01 : 2'b01;

        // Random traffic with intermittent in_valid.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            x4 = 4'($urandom_range(15));
            y4 = 4'($urandom_range(15));
            z4 = 1'($urandom_range(1));
            v4 = ($urandom_range(3) != 0);
            x1 = 1'($urandom_range(1));
            y1 = 1'($urandom_range(1));
            z1 = 1'($urandom_range(1));
            v1 = ($urandom_range(3) != 0);
            if (v4) exp4 = 5'(int'(x4) + int'(y4) + int'(z4));
            if (v1) exp1 = 2'(int'(x1) + int'(y1) + int'(z1));
            #1;
            chk("rnd_comb", 32'({ovc, cc, sc}), {29'd0, v1, 2'(int'(x1) + int'(y1) + int'(z1))});
            @(posedge clk) #1;
            chk("rnd_w4", 32'({c4, s4}), 32'(exp4));
            chk("rnd_w4_ov", 32'(ov4), 32'(v4));
            chk("rnd_w1", 32'({c1, s1}), 32'(exp1));
            chk("rnd_w1_ov", 32'(ov1), 32'(v1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
